iir_cascade_tdm: RTL and testbench

Multi-channel cascade of NSEC direct-form-I biquad sections sharing one time-multiplexed multiplier/accumulator. It sits between the audio sample source and the output serializer. It is the parametrised successor of the single-section 16-bit filter, and adds:
- a section count parameter;
- per-channel history banks;
- a runtime-writable coefficient bank;
- an internal wide accumulator with round-and-saturate between sections.

---
 rtl/iir_cascade_tdm_if.sv | 34 +++
 rtl/iir_cascade_tdm.sv | 176 +++++++++++++++++
 tb/tb_iir_cascade_tdm.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_cascade_tdm_if.sv
// Sample/coefficient/result bundle for the time-multiplexed biquad cascade.
// The testbench drives the master side and the filter uses the slave side.
interface iir_cascade_tdm_if #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int NSEC = 4,
  parameter int NCH  = 2
) ();
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(NSEC) + 3;

  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch;
  logic signed [DW-1:0]  in_sample;
  logic                  coef_we;
  logic [AW-1:0]         coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [DW-1:0]  out_sample;
  logic                  sat_flag;
  logic                  sat_clr;

  modport master (
    output in_valid, in_ch, in_sample, coef_we, coef_addr, coef_data, sat_clr,
    input  in_ready, out_valid, out_ch, out_sample, sat_flag
  );

  modport slave (
    input  in_valid, in_ch, in_sample, coef_we, coef_addr, coef_data, sat_clr,
    output in_ready, out_valid, out_ch, out_sample, sat_flag
  );
endinterface

// File: rtl/iir_cascade_tdm.sv
// Multi-channel cascade of direct-form-I biquads sharing one registered
// multiplier and one wide accumulator; 6 cycles per section.
//
// state   | meaning
// IDLE    | ready for a sample; coefficient writes allowed when no sample offered
// MAC     | 5 products of the current section, one per cycle (down-counter mac_cnt)
// SEC_END | absorb last product, round/saturate, update history, next section
// DONE    | one-cycle result strobe
module iir_cascade_tdm #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int NSEC = 4,
  parameter int NCH  = 2,
  parameter int ACCW = 40
) (
  input logic              clk,
  input logic              reset,
  iir_cascade_tdm_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int AW  = $clog2(NSEC) + 3;
  localparam int PW  = CW + DW;

  localparam logic signed [CW-1:0]   PASS = CW'(1) << FRAC;
  localparam logic signed [ACCW-1:0] RND  = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, SEC_END, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]              mac_cnt;
  logic [2:0]              idx;
  logic [SW-1:0]           sec;
  logic [CHW-1:0]          ch;
  logic signed [DW-1:0]    cur_x;
  logic signed [CW-1:0]    coef [NSEC][5];
  logic signed [DW-1:0]    x1 [NCH][NSEC];
  logic signed [DW-1:0]    x2 [NCH][NSEC];
  logic signed [DW-1:0]    y1 [NCH][NSEC];
  logic signed [DW-1:0]    y2 [NCH][NSEC];
  logic signed [PW-1:0]    prod;
  logic                    prod_neg;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [ACCW-1:0]  rnd;
  logic signed [DW-1:0]    res;
  logic                    clip;
  logic signed [CW-1:0]    coef_op;
  logic signed [DW-1:0]    data_op;
  logic signed [PW-1:0]    coef_ext;
  logic signed [PW-1:0]    data_ext;
  logic [AW-1:0]           wsec;
  logic                    wr_ok;
  logic                    last_sec;

  assign idx      = 3'd4 - mac_cnt;
  assign last_sec = (sec == SW'(NSEC - 1));
  assign wsec     = bus.coef_addr >> 3;
  assign wr_ok    = (wsec < AW'(NSEC)) && (bus.coef_addr[2:0] < 3'd5);

  always_comb begin
    coef_op = '0;
    data_op = '0;
    case (idx)
      3'd0: begin coef_op = coef[sec][0]; data_op = cur_x;        end
      3'd1: begin coef_op = coef[sec][1]; data_op = x1[ch][sec];  end
      3'd2: begin coef_op = coef[sec][2]; data_op = x2[ch][sec];  end
      3'd3: begin coef_op = coef[sec][3]; data_op = y1[ch][sec];  end
      3'd4: begin coef_op = coef[sec][4]; data_op = y2[ch][sec];  end
      default: ;
    endcase
  end

  assign coef_ext = {{DW{coef_op[CW-1]}}, coef_op};
  assign data_ext = {{CW{data_op[DW-1]}}, data_op};
  assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
  // Feedback terms enter subtracted so a1/a2 = -2^(CW-1) stays exact.
  assign acc_sum  = prod_neg ? (acc - prod_ext) : (acc + prod_ext);
  assign rnd      = (acc_sum + RND) >>> FRAC;

  always_comb begin
    clip = 1'b0;
    res  = rnd[DW-1:0];
    if (rnd > SMAX) begin
      res  = SMAX[DW-1:0];
      clip = 1'b1;
    end else if (rnd < SMIN) begin
      res  = SMIN[DW-1:0];
      clip = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = MAC;
      MAC:     if (mac_cnt == 3'd0) state_nx = SEC_END;
      SEC_END: state_nx = last_sec ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = reset && (state == IDLE);
  assign bus.out_valid = reset && (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mac_cnt        <= 3'd4;
      sec            <= '0;
      ch             <= '0;
      cur_x          <= '0;
      prod           <= '0;
      prod_neg       <= 1'b0;
      acc            <= '0;
      bus.out_sample <= '0;
      bus.out_ch     <= '0;
      bus.sat_flag   <= 1'b0;
      for (int s = 0; s < NSEC; s++) begin
        coef[s][0] <= PASS;
        for (int k = 1; k < 5; k++) coef[s][k] <= '0;
        for (int c = 0; c < NCH; c++) begin
          x1[c][s] <= '0;
          x2[c][s] <= '0;
          y1[c][s] <= '0;
          y2[c][s] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          mac_cnt <= 3'd4;
          sec     <= '0;
          if (bus.in_valid) begin
            cur_x <= bus.in_sample;
            ch    <= bus.in_ch;
          end else if (bus.coef_we && wr_ok) begin
            coef[wsec[SW-1:0]][bus.coef_addr[2:0]] <= bus.coef_data;
          end
        end
        MAC: begin
          prod     <= coef_ext * data_ext;
          prod_neg <= (idx >= 3'd3);
          acc      <= (mac_cnt == 3'd4) ? '0 : acc_sum;
          if (mac_cnt != 3'd0) mac_cnt <= mac_cnt - 3'd1;
        end
        SEC_END: begin
          x2[ch][sec] <= x1[ch][sec];
          x1[ch][sec] <= cur_x;
          y2[ch][sec] <= y1[ch][sec];
          y1[ch][sec] <= res;
          cur_x       <= res;
          mac_cnt     <= 3'd4;
          sec         <= sec + 1'b1;
          if (last_sec) begin
            bus.out_sample <= res;
            bus.out_ch     <= ch;
          end
        end
        default: ;
      endcase

      if ((state == SEC_END) && clip) bus.sat_flag <= 1'b1;
      else if (bus.sat_clr)           bus.sat_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iir_cascade_tdm.sv
// Directed and randomized checks of iir_cascade_tdm against an arithmetic
// per-channel cascade model held in plain arrays.
module tb_iir_cascade_tdm;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;
  localparam int NSEC = 4;
  localparam int NCH  = 2;
  localparam int ACCW = 40;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW   = $clog2(NSEC) + 3;
  localparam int LAT  = 6 * NSEC + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iir_cascade_tdm_if #(.DW(DW), .CW(CW), .NSEC(NSEC), .NCH(NCH)) bus ();

  iir_cascade_tdm #(
    .DW(DW), .CW(CW), .FRAC(FRAC), .NSEC(NSEC), .NCH(NCH), .ACCW(ACCW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  longint m_coef [NSEC][5];
  longint mx1 [NCH][NSEC];
  longint mx2 [NCH][NSEC];
  longint my1 [NCH][NSEC];
  longint my2 [NCH][NSEC];
  bit     m_sat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NSEC; s++) begin
      m_coef[s][0] = 64'sd1 << FRAC;
      for (int k = 1; k < 5; k++) m_coef[s][k] = 0;
      for (int c = 0; c < NCH; c++) begin
        mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
      end
    end
    m_sat = 1'b0;
  endfunction

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded half up and clamped per section
  function automatic longint model_step(input int c, input longint x,
                                        output bit clip_any, output bit clip_last);
    longint v, acc, r;
    longint lo, hi;
    lo = -(64'sd1 << (DW - 1));
    hi = (64'sd1 << (DW - 1)) - 1;
    v = x;
    clip_any = 1'b0;
    clip_last = 1'b0;
    for (int s = 0; s < NSEC; s++) begin
      acc = m_coef[s][0] * v + m_coef[s][1] * mx1[c][s] + m_coef[s][2] * mx2[c][s]
          - m_coef[s][3] * my1[c][s] - m_coef[s][4] * my2[c][s];
      r = (acc + (64'sd1 << (FRAC - 1))) >>> FRAC;
      clip_last = 1'b0;
      if (r > hi) begin r = hi; clip_last = 1'b1; end
      if (r < lo) begin r = lo; clip_last = 1'b1; end
      clip_any |= clip_last;
      mx2[c][s] = mx1[c][s];
      mx1[c][s] = v;
      my2[c][s] = my1[c][s];
      my1[c][s] = r;
      v = r;
    end
    return v;
  endfunction

  // All tasks start and end at a falling edge with the filter idle.
  task automatic write_coef(input int s, input int k, input int val, input bit honoured);
    logic [AW-1:0] a;
    logic [CW-1:0] d;
    a = AW'((s << 3) | k);
    d = CW'(val);
    bus.coef_we = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (honoured) m_coef[s][k] = val;
  endtask

  task automatic pulse_clr();
    bus.sat_clr = 1'b1;
    @(negedge clk);
    bus.sat_clr = 1'b0;
    m_sat = 1'b0;
    chk("sat_cleared", bus.sat_flag, 0);
  endtask

  task automatic send(input int c, input int x, input bit busy_wr, input bit clr_hold);
    longint y, sat_exp;
    bit clip_any, clip_last;
    int lat;
    logic [CHW-1:0] cv;
    logic [DW-1:0] xv;
    y = model_step(c, x, clip_any, clip_last);
    if (clr_hold) begin
      sat_exp = clip_last;
      m_sat = 1'b0;
    end else begin
      m_sat = m_sat | clip_any;
      sat_exp = m_sat;
    end
    cv = CHW'(c);
    xv = DW'(x);
    chk("ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_ch = cv;
    bus.in_sample = xv;
    bus.sat_clr = clr_hold;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    chk("ready_busy", bus.in_ready, 0);
    while (bus.out_valid !== 1'b1 && lat < 300) begin
      if (busy_wr && lat == 3) begin
        bus.coef_we = 1'b1;
        bus.coef_addr = AW'(8);
        bus.coef_data = '0;
      end
      @(negedge clk);
      lat++;
      bus.coef_we = 1'b0;
    end
    chk("latency", lat, LAT);
    chk("out_sample", $signed(bus.out_sample), y);
    chk("out_ch", bus.out_ch, c);
    chk("sat_flag", bus.sat_flag, sat_exp);
    @(negedge clk);
    bus.sat_clr = 1'b0;
    chk("valid_pulse", bus.out_valid, 0);
    chk("ready_after", bus.in_ready, 1);
    chk("out_hold", $signed(bus.out_sample), y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov;
    bus.in_valid = 1'b0;
    bus.in_ch = '0;
    bus.in_sample = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.sat_clr = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sample", bus.out_sample, 0);
    chk("rst_ch", bus.out_ch, 0);
    chk("rst_sat", bus.sat_flag, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_post_rst", bus.in_ready, 1);

    // passthrough
    send(0, 1000, 0, 0);

    // b0 = 0.5 on section 0
    write_coef(0, 0, 8192, 1);
    send(0, 16384, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    write_coef(0, 0, 16384, 1);

    // one-pole feedback y = x + 0.5*y1, ch1 interleaved
    write_coef(0, 3, -8192, 1);
    send(0, 16384, 0, 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    write_coef(0, 3, 0, 1);

    // saturation, sticky flag and clear
    write_coef(0, 0, 32767, 1);
    send(0, 32767, 0, 0);
    pulse_clr();
    send(0, -32768, 0, 0);
    write_coef(0, 0, 16384, 1);
    pulse_clr();

    // clip in the final section while sat_clr is held: set wins
    write_coef(NSEC - 1, 0, 32767, 1);
    send(1, 20000, 0, 1);
    chk("sat_after_clr", bus.sat_flag, 0);
    write_coef(NSEC - 1, 0, 16384, 1);

    // write while busy is dropped, write in idle takes effect, bad index ignored
    send(0, 500, 1, 0);
    send(0, 500, 0, 0);
    write_coef(1, 5, 0, 0);
    send(1, 700, 0, 0);
    write_coef(1, 0, 0, 1);
    send(0, 500, 0, 0);
    write_coef(1, 0, 16384, 1);

    // reset mid-calculation
    write_coef(2, 0, 8192, 1);
    write_coef(2, 3, 4000, 1);
    bus.in_valid = 1'b1;
    bus.in_ch = '0;
    bus.in_sample = 16'sd3000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    ov = 0;
    repeat (9) begin
      if (bus.out_valid === 1'b1) ov++;
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_ready", bus.in_ready, 0);
      if (bus.out_valid === 1'b1) ov++;
    end
    reset = 1'b1;
    model_reset();
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov++;
    end
    chk("midrst_no_valid", ov, 0);
    chk("midrst_sample", bus.out_sample, 0);
    send(0, 1234, 0, 0);
    send(1, -1234, 0, 0);

    // randomized coefficients and samples
    for (int s = 0; s < NSEC; s++) begin
      write_coef(s, 0, int'($urandom_range(0, 24575)) - 4096, 1);
      write_coef(s, 1, int'($urandom_range(0, 16383)) - 8192, 1);
      write_coef(s, 2, int'($urandom_range(0, 8191)) - 4096, 1);
      write_coef(s, 3, int'($urandom_range(0, 8191)) - 4096, 1);
      write_coef(s, 4, int'($urandom_range(0, 4095)) - 2048, 1);
    end
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 65535)) - 32768, 0, 0);
      if (i % 10 == 5) pulse_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
